uctl_fifo_pkt_writer: RTL and testbench

//  Write-side packet engine for the uctl async FIFO. Accepts a length-tagged packet stream from the protocol layer.

---
 rtl/uctl_fifo_pkg.sv | 33 +++
 rtl/uctl_fifo_pkt_writer.sv | 179 +++++++++++++++++
 tb/tb_uctl_fifo_pkt_writer.sv | 561 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uctl_fifo_pkg.sv
// Shared definitions for the uctl async FIFO packet path (wclk writer and rclk reader).
package uctl_fifo_pkg;

  localparam int unsigned DataW = 23;
  localparam int unsigned LenW  = 11;
  localparam int unsigned EpW   = 4;

  // Tag bits sitting above the payload in every FIFO word.
  localparam int unsigned CtlBit  = DataW + 1;
  localparam int unsigned LastBit = DataW;

  typedef enum logic [2:0] {
    StIdle,
    StChk,
    StHdr,
    StData,
    StDrop
  } wr_state_e;

  // Header payload: {ep, len} zero-extended to the payload width.
  function automatic logic [DataW-1:0] hdr_pack(input logic [EpW-1:0]  ep,
                                                input logic [LenW-1:0] len);
    return {{(DataW - EpW - LenW){1'b0}}, ep, len};
  endfunction

  function automatic void hdr_unpack(input  logic [DataW-1:0] payload,
                                     output logic [EpW-1:0]   ep,
                                     output logic [LenW-1:0]  len);
    len = payload[LenW-1:0];
    ep  = payload[LenW +: EpW];
  endfunction

endpackage

// File: rtl/uctl_fifo_pkt_writer.sv
// Write-side packet engine: reserves FIFO space for a whole packet, then pushes a
// header word followed by the data words, tagged {is_ctl, last, payload}.
module uctl_fifo_pkt_writer
  import uctl_fifo_pkg::*;
#(
  parameter int unsigned DATA_W        = 23,
  parameter int unsigned FIFO_ADDRSIZE = 2,
  parameter int unsigned LEN_W         = 11,
  parameter int unsigned EP_W          = 4
) (
  input  logic                     wclk,
  input  logic                     rrst_n,
  input  logic                     swRst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic                     in_abort,
  input  logic [LEN_W-1:0]         in_len,
  input  logic [EP_W-1:0]          in_ep,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     w_en,
  output logic [DATA_W+1:0]        fifo_data_in,
  input  logic                     wfull,
  input  logic [FIFO_ADDRSIZE:0]   numOfFreeLocs,
  output logic                     busy,
  output logic                     pkt_done,
  output logic                     pkt_err
);

  localparam int unsigned Depth = 1 << FIFO_ADDRSIZE;
  localparam int unsigned PadW  = DATA_W - EP_W - LEN_W;
  localparam logic [LEN_W:0] DepthExt = (LEN_W + 1)'(Depth);

  wr_state_e         state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [EP_W-1:0]   ep_q, ep_d;

  logic              out_en;
  logic [LEN_W:0]    need;
  logic [LEN_W:0]    free_ext;
  logic              cnt_at_last;
  logic              is_ctl;
  logic              last;
  logic [DATA_W-1:0] payload;

  // Outputs are forced quiet while either reset is active.
  assign out_en      = rrst_n & ~swRst;
  assign busy        = out_en & (state_q != StIdle);
  assign need        = {1'b0, len_q} + (LEN_W + 1)'(1);
  assign free_ext    = {{(LEN_W - FIFO_ADDRSIZE){1'b0}}, numOfFreeLocs};
  assign cnt_at_last = (cnt_q == (len_q - LEN_W'(1)));

  // Next-state, handshake and FIFO word generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ep_d     = ep_q;
    in_ready = 1'b0;
    w_en     = 1'b0;
    is_ctl   = 1'b0;
    last     = 1'b0;
    payload  = '0;
    pkt_done = 1'b0;
    pkt_err  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Non-sop beats here belong to no packet: swallow and flag them.
        in_ready = in_valid & ~in_sop;
        pkt_err  = in_valid & ~in_sop;
        if (in_valid && in_sop) begin
          len_d   = in_len;
          ep_d    = in_ep;
          state_d = StChk;
        end
      end
      StChk: begin
        if (need > DepthExt) begin
          pkt_err = 1'b1;
          state_d = StDrop;
        end else if ((free_ext >= need) && !wfull) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (!wfull) begin
          w_en    = 1'b1;
          is_ctl  = 1'b1;
          last    = (len_q == '0);
          payload = {{PadW{1'b0}}, ep_q, len_q};
          if (len_q == '0) begin
            // Zero-length packet: the sop beat carries no data and is consumed here.
            in_ready = 1'b1;
            pkt_done = 1'b1;
            if (in_eop) begin
              state_d = StIdle;
            end else begin
              pkt_err = 1'b1;
              state_d = StDrop;
            end
          end else begin
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        in_ready = ~wfull;
        if (in_valid && !wfull) begin
          w_en  = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (in_abort) begin
            is_ctl  = 1'b1;
            last    = 1'b1;
            pkt_err = 1'b1;
            state_d = StIdle;
          end else begin
            last    = in_eop | cnt_at_last;
            payload = in_data;
            if (cnt_at_last) begin
              if (in_eop) begin
                pkt_done = 1'b1;
                state_d  = StIdle;
              end else begin
                pkt_err = 1'b1;
                state_d = StDrop;
              end
            end else if (in_eop) begin
              pkt_err = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      StDrop: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!out_en) begin
      in_ready = 1'b0;
      w_en     = 1'b0;
      pkt_done = 1'b0;
      pkt_err  = 1'b0;
    end

    if (swRst) begin
      state_d = StIdle;
      cnt_d   = '0;
      len_d   = '0;
      ep_d    = '0;
    end

    fifo_data_in = w_en ? {is_ctl, last, payload} : '0;
  end

  // State and packet context registers.
  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ep_q    <= ep_d;
    end
  end

endmodule

// File: tb/tb_uctl_fifo_pkt_writer.sv
// Self-checking bench for uctl_fifo_pkt_writer with a packet-level reference model.
module tb_uctl_fifo_pkt_writer;

  localparam int Depth = 4;

  logic        wclk = 1'b0;
  logic        rrst_n;
  logic        swRst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic        in_abort;
  logic [10:0] in_len;
  logic [3:0]  in_ep;
  logic [22:0] in_data;
  logic        w_en;
  logic [24:0] fifo_data_in;
  logic        wfull;
  logic [2:0]  numOfFreeLocs;
  logic        busy;
  logic        pkt_done;
  logic        pkt_err;

  int checks = 0;
  int errors = 0;

  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  int          done_n, err_n, viol_n;
  int          exp_done, exp_err;
  logic [22:0] beat_data[16];
  bit          tog_run;

  uctl_fifo_pkt_writer dut (
    .wclk         (wclk),
    .rrst_n       (rrst_n),
    .swRst        (swRst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_abort     (in_abort),
    .in_len       (in_len),
    .in_ep        (in_ep),
    .in_data      (in_data),
    .w_en         (w_en),
    .fifo_data_in (fifo_data_in),
    .wfull        (wfull),
    .numOfFreeLocs(numOfFreeLocs),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err)
  );

  always #5 wclk = ~wclk;

  // Monitor: capture FIFO writes and status pulses mid-cycle.
  always @(negedge wclk) begin
    if (rrst_n) begin
      if (w_en) begin
        got_q.push_back(fifo_data_in);
        if (wfull) viol_n++;
      end
      if (pkt_done) done_n++;
      if (pkt_err) err_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic clr();
    got_q.delete();
    done_n = 0;
    err_n  = 0;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 16; i++) beat_data[i] = 23'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_abort = 1'b0;
    repeat (n) @(posedge wclk);
    #1;
  endtask

  // Reference: words a packet should leave in the FIFO, plus done/err pulse counts.
  // The last driven beat (index nbeats-1) carries eop.
  task automatic build_expect(input int len, input int ep, input int nbeats, input int abort_idx);
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    if (len + 1 > Depth) begin
      exp_err = 1;
      return;
    end
    exp_q.push_back({1'b1, (len == 0), 8'd0, 4'(ep), 11'(len)});
    if (len == 0) begin
      exp_done = 1;
      if (nbeats != 1) exp_err = 1;
      return;
    end
    for (int i = 0; i < nbeats; i++) begin
      bit lst;
      if (i == abort_idx) begin
        exp_q.push_back({2'b11, 23'd0});
        exp_err = 1;
        return;
      end
      lst = (i == nbeats - 1) || (i == len - 1);
      exp_q.push_back({1'b0, lst, beat_data[i]});
      if (lst) begin
        if (i == len - 1 && i == nbeats - 1) exp_done = 1;
        else exp_err = 1;
        return;
      end
    end
  endtask

  // Drive one packet beat by beat with valid/ready handshakes.
  task automatic send_pkt(input int len, input int ep, input int nbeats, input int abort_idx,
                          input int gap_max);
    for (int i = 0; i < nbeats; i++) begin
      int n;
      bit got;
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) @(posedge wclk);
        #1;
      end
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == nbeats - 1);
      in_abort = (i == abort_idx);
      in_len   = 11'(len);
      in_ep    = 4'(ep);
      in_data  = beat_data[i];
      n = 0;
      got = 1'b0;
      while (!got && n < 300) begin
        @(negedge wclk);
        got = in_ready;
        n++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL send_pkt handshake: beat %0d of len %0d, in_ready=0 (required 1)", i, len);
        in_valid = 1'b0;
        return;
      end
      @(posedge wclk);
      #1;
      if (i == abort_idx) break;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_abort = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({w_en, in_ready, busy, pkt_done, pkt_err} !== 5'b0 || fifo_data_in !== 25'd0) begin
      errors++;
      $display("FAIL reset outputs: got w_en/rdy/busy/done/err=%b data=%h, required all 0",
               {w_en, in_ready, busy, pkt_done, pkt_err}, fifo_data_in);
    end
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset stray gating: got rdy=%b err=%b, required 0 0", in_ready, pkt_err);
    end
    in_valid = 1'b0;
    @(posedge wclk);
    #3;
    rrst_n = 1'b1;
    @(posedge wclk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_stray();
    in_valid = 1'b1;
    in_sop   = 1'b0;
    @(negedge wclk);
    checks++;
    if (in_ready !== 1'b1 || pkt_err !== 1'b1 || w_en !== 1'b0) begin
      errors++;
      $display("FAIL stray beat: got rdy=%b err=%b w_en=%b, required 1 1 0",
               in_ready, pkt_err, w_en);
    end
    @(posedge wclk);
    #1;
    idle(2);
  endtask

  task automatic test_basic();
    clr();
    fill_data();
    build_expect(3, 5, 3, -1);
    fork
      send_pkt(3, 5, 3, -1, 0);
      begin
        @(negedge wclk);
        checks++;
        if (w_en !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL basic idle cycle: got w_en=%b busy=%b, required 0 0", w_en, busy);
        end
        @(negedge wclk);
        checks++;
        if (w_en !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL basic chk cycle: got w_en=%b busy=%b, required 0 1", w_en, busy);
        end
        @(negedge wclk);
        checks++;
        if (w_en !== 1'b1 || fifo_data_in !== exp_q[0]) begin
          errors++;
          $display("FAIL basic hdr latency: got w_en=%b data=%h, required 1 %h",
                   w_en, fifo_data_in, exp_q[0]);
        end
      end
    join
    idle(3);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic word count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL basic word %0d: got %h, required %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (done_n !== 1 || err_n !== 0) begin
      errors++;
      $display("FAIL basic pulses: got done=%0d err=%0d, required 1 0", done_n, err_n);
    end
  endtask

  task automatic test_chk_hold();
    clr();
    fill_data();
    build_expect(3, 2, 3, -1);
    numOfFreeLocs = 3'd2;
    fork
      send_pkt(3, 2, 3, -1, 0);
      begin
        repeat (10) @(negedge wclk);
        checks++;
        if (got_q.size() !== 0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL chk_hold held: got %0d writes busy=%b, required 0 writes busy=1",
                   got_q.size(), busy);
        end
        #1;
        numOfFreeLocs = 3'd4;
      end
    join
    idle(3);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL chk_hold word count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL chk_hold word %0d: got %h, required %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (done_n !== exp_done || err_n !== exp_err) begin
      errors++;
      $display("FAIL chk_hold pulses: got done=%0d err=%0d, required %0d %0d",
               done_n, err_n, exp_done, exp_err);
    end
  endtask

  task automatic test_framing();
    string nm[8];
    int    f_len[8];
    int    f_nb[8];
    int    f_ab[8];
    nm    = '{"early_eop", "late_eop", "abort", "oversize", "abort_last", "len0", "len1",
              "oversize5"};
    f_len = '{3, 2, 3, 4, 3, 0, 1, 5};
    f_nb  = '{2, 4, 3, 4, 3, 1, 1, 2};
    f_ab  = '{-1, -1, 1, -1, 2, -1, -1, -1};
    for (int c = 0; c < 8; c++) begin
      int ep;
      ep = int'($urandom_range(0, 15));
      clr();
      fill_data();
      build_expect(f_len[c], ep, f_nb[c], f_ab[c]);
      send_pkt(f_len[c], ep, f_nb[c], f_ab[c], 1);
      idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL %s word count: got %0d, required %0d", nm[c], got_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (got_q[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL %s word %0d: got %h, required %h", nm[c], k, got_q[k], exp_q[k]);
          end
        end
      end
      checks++;
      if (done_n !== exp_done || err_n !== exp_err || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s status: got done=%0d err=%0d busy=%b, required %0d %0d 0",
                 nm[c], done_n, err_n, busy, exp_done, exp_err);
      end
    end
  endtask

  task automatic test_swrst();
    int  n;
    bit  got;
    clr();
    fill_data();
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_eop   = 1'b0;
    in_abort = 1'b0;
    in_len   = 11'd3;
    in_ep    = 4'd1;
    in_data  = beat_data[0];
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge wclk);
      got = in_ready;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL swrst setup: in_ready=0, required 1");
    end
    @(posedge wclk);
    #1;
    in_sop  = 1'b0;
    in_data = beat_data[1];
    @(posedge wclk);
    #1;
    swRst   = 1'b1;
    in_eop  = 1'b1;
    in_data = beat_data[2];
    @(negedge wclk);
    checks++;
    if (w_en !== 1'b0 || in_ready !== 1'b0 || pkt_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL swrst cycle: got w_en=%b rdy=%b err=%b busy=%b, required 0 0 0 0",
               w_en, in_ready, pkt_err, busy);
    end
    @(posedge wclk);
    #1;
    swRst = 1'b0;
    idle(0);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL swrst idle: got busy=%b, required 0", busy);
    end
    idle(5);
    checks++;
    if (got_q.size() !== 3) begin
      errors++;
      $display("FAIL swrst writes: got %0d, required 3", got_q.size());
    end
    clr();
    fill_data();
    build_expect(2, 7, 2, -1);
    send_pkt(2, 7, 2, -1, 0);
    idle(3);
    checks++;
    if (got_q !== exp_q || done_n !== 1 || err_n !== 0) begin
      errors++;
      $display("FAIL swrst follow-up: got %0d words done=%0d err=%0d, required %0d words 1 0",
               got_q.size(), done_n, err_n, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    fill_data();
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_len   = 11'd3;
    in_ep    = 4'd9;
    in_data  = beat_data[0];
    repeat (4) @(posedge wclk);
    #1;
    in_sop  = 1'b0;
    in_data = beat_data[1];
    #2;
    rrst_n = 1'b0;
    #1;
    checks++;
    if ({w_en, in_ready, busy, pkt_done, pkt_err} !== 5'b0 || fifo_data_in !== 25'd0) begin
      errors++;
      $display("FAIL async reset: got w_en/rdy/busy/done/err=%b data=%h, required all 0",
               {w_en, in_ready, busy, pkt_done, pkt_err}, fifo_data_in);
    end
    in_valid = 1'b0;
    @(negedge wclk);
    #1;
    rrst_n = 1'b1;
    @(posedge wclk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL async reset idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] tmp_q[$];
    int          d1, e1;
    clr();
    fill_data();
    build_expect(2, 3, 2, -1);
    tmp_q = exp_q;
    d1 = exp_done;
    e1 = exp_err;
    build_expect(3, 4, 3, -1);
    exp_q = {tmp_q, exp_q};
    send_pkt(2, 3, 2, -1, 0);
    send_pkt(3, 4, 3, -1, 0);
    idle(3);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b word count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL b2b word %0d: got %h, required %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (done_n !== d1 + exp_done || err_n !== e1 + exp_err) begin
      errors++;
      $display("FAIL b2b pulses: got done=%0d err=%0d, required %0d %0d",
               done_n, err_n, d1 + exp_done, e1 + exp_err);
    end
  endtask

  task automatic test_random();
    viol_n  = 0;
    tog_run = 1'b1;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len, nb, ab, ep, mode;
          len  = int'($urandom_range(0, 5));
          ep   = int'($urandom_range(0, 15));
          ab   = -1;
          mode = int'($urandom_range(0, 5));
          if (len == 0) nb = 1;
          else if (len + 1 > Depth) nb = int'($urandom_range(1, 4));
          else if (mode == 3) nb = int'($urandom_range(1, len));
          else if (mode == 4) nb = len + int'($urandom_range(1, 2));
          else nb = len;
          if (len >= 1 && len + 1 <= Depth && $urandom_range(0, 5) == 0)
            ab = int'($urandom_range(0, ((len < nb) ? len : nb) - 1));
          clr();
          fill_data();
          build_expect(len, ep, nb, ab);
          send_pkt(len, ep, nb, ab, 2);
          idle(3);
          checks++;
          if (got_q !== exp_q || done_n !== exp_done || err_n !== exp_err) begin
            errors++;
            $display("FAIL random pkt %0d len=%0d nb=%0d ab=%0d: got %0d words done=%0d err=%0d, required %0d words %0d %0d",
                     p, len, nb, ab, got_q.size(), done_n, err_n, exp_q.size(),
                     exp_done, exp_err);
          end
        end
        tog_run = 1'b0;
      end
      begin
        while (tog_run) begin
          @(posedge wclk);
          #2;
          wfull = ($urandom_range(0, 3) == 0);
        end
        wfull = 1'b0;
      end
    join
    checks++;
    if (viol_n !== 0) begin
      errors++;
      $display("FAIL random wfull guard: got %0d writes while full, required 0", viol_n);
    end
  endtask

  initial begin
    rrst_n        = 1'b0;
    swRst         = 1'b0;
    in_valid      = 1'b0;
    in_sop        = 1'b0;
    in_eop        = 1'b0;
    in_abort      = 1'b0;
    in_len        = '0;
    in_ep         = '0;
    in_data       = '0;
    wfull         = 1'b0;
    numOfFreeLocs = 3'd4;
    done_n        = 0;
    err_n         = 0;
    viol_n        = 0;

    test_reset();
    test_stray();
    test_basic();
    test_chk_hold();
    test_framing();
    test_swrst();
    test_async_reset();
    test_back_to_back();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
